// File: rtl/fp_pkg.sv
// Shared types and sizes for the FP register file / scoreboard slice.
// Optional feature macro used by this slice: FP_WB_BYPASS_EN.
package fp_pkg;

   localparam int unsigned FP_NUM_REGS = 16;
   localparam int unsigned FP_DATA_W   = 32;
   localparam int unsigned FP_ADDR_W   = 4;
   localparam int unsigned FP_EXP_W    = 8;
   localparam int unsigned FP_MAN_W    = 23;

   typedef logic [FP_DATA_W-1:0] fp_word_t;
   typedef logic [FP_ADDR_W-1:0] reg_idx_t;

endpackage

// File: rtl/fp_regfile_sb_if.sv
// Bus between the decoder/add_block side (master) and the register file (slave).
// The register file behaviour depends on macro FP_WB_BYPASS_EN; the bus does not.
interface fp_regfile_sb_if
   import fp_pkg::*;
#(
   parameter int unsigned NUM_REGS = FP_NUM_REGS,
   parameter int unsigned DATA_W   = FP_DATA_W,
   parameter int unsigned ADDR_W   = FP_ADDR_W
);

   // host load port
   logic              load_en;
   logic [ADDR_W-1:0] load_addr;
   logic [DATA_W-1:0] load_data;
   logic              load_err;

   // operand reads
   logic [ADDR_W-1:0] rd_addr_a;
   logic [ADDR_W-1:0] rd_addr_b;
   logic [DATA_W-1:0] rd_data_a;
   logic [DATA_W-1:0] rd_data_b;

   // issue handshake
   logic              issue_valid;
   logic [ADDR_W-1:0] issue_dest;
   logic              issue_ready;
   logic              issue_fire;

   // writeback from add_block
   logic              wb_en;
   logic [ADDR_W-1:0] wb_dest;
   logic [DATA_W-1:0] wb_data;

   // status
   logic [NUM_REGS-1:0] busy_vec;
   logic                idle;

   modport master (
      output load_en, load_addr, load_data,
      output rd_addr_a, rd_addr_b,
      output issue_valid, issue_dest,
      output wb_en, wb_dest, wb_data,
      input  load_err, rd_data_a, rd_data_b,
      input  issue_ready, issue_fire, busy_vec, idle
   );

   modport slave (
      input  load_en, load_addr, load_data,
      input  rd_addr_a, rd_addr_b,
      input  issue_valid, issue_dest,
      input  wb_en, wb_dest, wb_data,
      output load_err, rd_data_a, rd_data_b,
      output issue_ready, issue_fire, busy_vec, idle
   );

endinterface

// File: rtl/fp_scoreboard.sv
// Per-register busy tracking and hazard check for in-order issue.
// With FP_WB_BYPASS_EN defined, a same-cycle writeback clears its busy bit for the
// hazard check; otherwise ready depends only on the registered busy vector.
module fp_scoreboard
   import fp_pkg::*;
#(
   parameter int unsigned NUM_REGS = FP_NUM_REGS,
   parameter int unsigned ADDR_W   = FP_ADDR_W
) (
   input  logic                clk,
   input  logic                nreset,
   input  logic                set_en,
   input  logic [ADDR_W-1:0]   set_idx,
   input  logic                clr_en,
   input  logic [ADDR_W-1:0]   clr_idx,
   input  logic [ADDR_W-1:0]   chk_a,
   input  logic [ADDR_W-1:0]   chk_b,
   input  logic [ADDR_W-1:0]   chk_d,
   output logic                ready,
   output logic [NUM_REGS-1:0] busy_vec
);

   logic [NUM_REGS-1:0] busy_q;
   logic [NUM_REGS-1:0] busy_d;
   logic [NUM_REGS-1:0] busy_chk;

   // Next busy state: clear on writeback, then set on issue so the set wins.
   always_comb begin
      busy_d = busy_q;
      if (clr_en) busy_d[clr_idx] = 1'b0;
      if (set_en) busy_d[set_idx] = 1'b1;
   end

   // Busy view used by the hazard check.
   always_comb begin
      busy_chk = busy_q;
`ifdef FP_WB_BYPASS_EN
      if (clr_en) busy_chk[clr_idx] = 1'b0;
`endif
   end

   // RAW on either source or WAW on the destination blocks issue.
   always_comb begin
      ready = ~busy_chk[chk_a] & ~busy_chk[chk_b] & ~busy_chk[chk_d];
   end

   // Busy register, discarded on reset.
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         busy_q <= '0;
      end else begin
         busy_q <= busy_d;
      end
   end

   assign busy_vec = busy_q;

endmodule

// File: rtl/fp_regfile_sb.sv
// FP register file with issue scoreboard, feeding add_block operands and
// consuming its writeback. Optional macro FP_WB_BYPASS_EN forwards writeback
// data to the read ports and releases the busy bit in the writeback cycle.
// ADDR_W must equal clog2(NUM_REGS).
module fp_regfile_sb
   import fp_pkg::*;
#(
   parameter int unsigned NUM_REGS = FP_NUM_REGS,
   parameter int unsigned DATA_W   = FP_DATA_W,
   parameter int unsigned ADDR_W   = FP_ADDR_W
) (
   input logic        clk,
   input logic        nreset,
   fp_regfile_sb_if.slave bus
);

   logic [DATA_W-1:0]   regs_q [NUM_REGS];
   logic [NUM_REGS-1:0] busy;
   logic                ready;
   logic                fire;
   logic                load_ok;
   logic                load_err_q;

   assign fire = bus.issue_valid & ready;

   // Load check uses the pre-edge busy vector, so a load racing an issue to the
   // same register still lands, and a load racing a writeback is rejected.
   assign load_ok = bus.load_en & ~busy[bus.load_addr];

   fp_scoreboard #(
      .NUM_REGS (NUM_REGS),
      .ADDR_W   (ADDR_W)
   ) u_scoreboard (
      .clk      (clk),
      .nreset   (nreset),
      .set_en   (fire),
      .set_idx  (bus.issue_dest),
      .clr_en   (bus.wb_en),
      .clr_idx  (bus.wb_dest),
      .chk_a    (bus.rd_addr_a),
      .chk_b    (bus.rd_addr_b),
      .chk_d    (bus.issue_dest),
      .ready    (ready),
      .busy_vec (busy)
   );

   // Register storage: host load, then writeback (writeback wins on a tie).
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         for (int i = 0; i < int'(NUM_REGS); i++) regs_q[i] <= '0;
      end else begin
         if (load_ok) regs_q[bus.load_addr] <= bus.load_data;
         if (bus.wb_en) regs_q[bus.wb_dest] <= bus.wb_data;
      end
   end

   // One-cycle pulse for a load dropped because its target was busy.
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         load_err_q <= 1'b0;
      end else begin
         load_err_q <= bus.load_en & busy[bus.load_addr];
      end
   end

   // Operand read muxes, optionally forwarding the writeback value.
   always_comb begin
      bus.rd_data_a = regs_q[bus.rd_addr_a];
      bus.rd_data_b = regs_q[bus.rd_addr_b];
`ifdef FP_WB_BYPASS_EN
      if (bus.wb_en && (bus.wb_dest == bus.rd_addr_a)) bus.rd_data_a = bus.wb_data;
      if (bus.wb_en && (bus.wb_dest == bus.rd_addr_b)) bus.rd_data_b = bus.wb_data;
`endif
   end

   assign bus.issue_ready = ready;
   assign bus.issue_fire  = fire;
   assign bus.busy_vec    = busy;
   assign bus.idle        = ~|busy;
   assign bus.load_err    = load_err_q;

endmodule

// File: tb/tb_fp_regfile_sb.sv
// Self-checking bench for fp_regfile_sb: directed scenarios plus randomized
// traffic against an array-based reference model. Honours FP_WB_BYPASS_EN.
module tb_fp_regfile_sb;
   import fp_pkg::*;

   logic tb_clk;
   logic nreset;
   int   checks;
   int   errors;

   fp_regfile_sb_if bus ();

   fp_regfile_sb dut (
      .clk    (tb_clk),
      .nreset (nreset),
      .bus    (bus)
   );

   initial tb_clk = 1'b0;
   always #5 tb_clk = ~tb_clk;

   // reference model state
   logic [31:0] m_regs [16];
   logic [15:0] m_busy;
   logic        m_lerr;

   function automatic logic [15:0] eff_busy();
      logic [15:0] b;
      b = m_busy;
`ifdef FP_WB_BYPASS_EN
      if (bus.wb_en) b[bus.wb_dest] = 1'b0;
`endif
      return b;
   endfunction

   function automatic logic exp_ready();
      logic [15:0] b;
      b = eff_busy();
      return !b[bus.rd_addr_a] && !b[bus.rd_addr_b] && !b[bus.issue_dest];
   endfunction

   function automatic logic [31:0] exp_rd(input logic [3:0] addr);
`ifdef FP_WB_BYPASS_EN
      if (bus.wb_en && bus.wb_dest == addr) return bus.wb_data;
`endif
      return m_regs[addr];
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 16; i++) m_regs[i] = '0;
      m_busy = '0;
      m_lerr = 1'b0;
   endtask

   task automatic clear_inputs();
      bus.load_en = 0; bus.load_addr = 0; bus.load_data = 0;
      bus.rd_addr_a = 0; bus.rd_addr_b = 0;
      bus.issue_valid = 0; bus.issue_dest = 0;
      bus.wb_en = 0; bus.wb_dest = 0; bus.wb_data = 0;
   endtask

   // Advance one clock, updating the model from the inputs present before the edge.
   task automatic tick();
      logic [31:0] n_regs [16];
      logic [15:0] n_busy;
      logic        n_lerr;
      logic        fire;
      fire   = bus.issue_valid && exp_ready();
      n_regs = m_regs;
      n_busy = m_busy;
      n_lerr = bus.load_en && m_busy[bus.load_addr];
      if (bus.load_en && !m_busy[bus.load_addr]) n_regs[bus.load_addr] = bus.load_data;
      if (bus.wb_en) n_regs[bus.wb_dest] = bus.wb_data;
      if (bus.wb_en) n_busy[bus.wb_dest] = 1'b0;
      if (fire) n_busy[bus.issue_dest] = 1'b1;
      @(posedge tb_clk);
      #1;
      m_regs = n_regs;
      m_busy = n_busy;
      m_lerr = n_lerr;
   endtask

   task automatic test_reset();
      clear_inputs();
      nreset = 1'b0;
      model_reset();
      #1;
      checks++;
      if (bus.busy_vec !== 16'h0000) begin
         errors++; $display("FAIL reset_busy got %h want 0000", bus.busy_vec);
      end
      checks++;
      if (bus.idle !== 1'b1 || bus.load_err !== 1'b0) begin
         errors++; $display("FAIL reset_flags idle %b load_err %b want 1 0", bus.idle, bus.load_err);
      end
      bus.rd_addr_a = 4'd9; bus.rd_addr_b = 4'd15;
      #1;
      checks++;
      if (bus.rd_data_a !== 32'h0 || bus.rd_data_b !== 32'h0) begin
         errors++; $display("FAIL reset_rd got %h %h want 0 0", bus.rd_data_a, bus.rd_data_b);
      end
      @(negedge tb_clk);
      nreset = 1'b1;
   endtask

   task automatic test_load();
      clear_inputs();
      bus.load_en = 1; bus.load_addr = 4'd3; bus.load_data = 32'h3F800000;
      tick();
      bus.load_addr = 4'd4; bus.load_data = 32'h40000000;
      tick();
      clear_inputs();
      bus.rd_addr_a = 4'd3; bus.rd_addr_b = 4'd4;
      #1;
      checks++;
      if (bus.rd_data_a !== 32'h3F800000) begin
         errors++; $display("FAIL load_a got %h want 3f800000", bus.rd_data_a);
      end
      checks++;
      if (bus.rd_data_b !== 32'h40000000) begin
         errors++; $display("FAIL load_b got %h want 40000000", bus.rd_data_b);
      end
      checks++;
      if (bus.load_err !== 1'b0 || bus.idle !== 1'b1) begin
         errors++; $display("FAIL load_flags load_err %b idle %b want 0 1", bus.load_err, bus.idle);
      end
   endtask

   task automatic test_raw();
      clear_inputs();
      bus.rd_addr_a = 4'd3; bus.rd_addr_b = 4'd4;
      bus.issue_valid = 1; bus.issue_dest = 4'd5;
      #1;
      checks++;
      if (bus.issue_fire !== 1'b1) begin
         errors++; $display("FAIL raw_fire got %b want 1", bus.issue_fire);
      end
      tick();
      clear_inputs();
      #1;
      checks++;
      if (bus.busy_vec !== 16'h0020 || bus.idle !== 1'b0) begin
         errors++; $display("FAIL raw_busy got %h idle %b want 0020 0", bus.busy_vec, bus.idle);
      end
      bus.rd_addr_a = 4'd5; bus.rd_addr_b = 4'd4;
      bus.issue_valid = 1; bus.issue_dest = 4'd6;
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++;
         if (bus.issue_ready !== 1'b0 || bus.issue_fire !== 1'b0) begin
            errors++;
            $display("FAIL raw_stall cyc %0d ready %b fire %b want 0 0", i, bus.issue_ready,
                     bus.issue_fire);
         end
         tick();
      end
      bus.issue_valid = 0;
      bus.wb_en = 1; bus.wb_dest = 4'd5; bus.wb_data = 32'h40400000;
      #1;
      checks++;
`ifdef FP_WB_BYPASS_EN
      if (bus.issue_ready !== 1'b1 || bus.rd_data_a !== 32'h40400000) begin
         errors++; $display("FAIL raw_wb_cycle ready %b rd %h want 1 40400000", bus.issue_ready,
                            bus.rd_data_a);
      end
`else
      if (bus.issue_ready !== 1'b0) begin
         errors++; $display("FAIL raw_wb_cycle ready %b want 0", bus.issue_ready);
      end
`endif
      tick();
      clear_inputs();
      bus.rd_addr_a = 4'd5; bus.rd_addr_b = 4'd4; bus.issue_dest = 4'd6;
      #1;
      checks++;
      if (bus.rd_data_a !== 32'h40400000 || bus.busy_vec !== 16'h0000) begin
         errors++; $display("FAIL raw_after_wb rd %h busy %h want 40400000 0000", bus.rd_data_a,
                            bus.busy_vec);
      end
      checks++;
      if (bus.issue_ready !== 1'b1) begin
         errors++; $display("FAIL raw_ready_after got %b want 1", bus.issue_ready);
      end
   endtask

   task automatic test_waw();
      clear_inputs();
      bus.issue_valid = 1; bus.issue_dest = 4'd5; bus.rd_addr_a = 4'd0; bus.rd_addr_b = 4'd1;
      tick();
      #1;
      checks++;
      if (bus.issue_ready !== 1'b0 || bus.issue_fire !== 1'b0) begin
         errors++; $display("FAIL waw_stall ready %b fire %b want 0 0", bus.issue_ready,
                            bus.issue_fire);
      end
      bus.issue_valid = 0;
      bus.wb_en = 1; bus.wb_dest = 4'd5; bus.wb_data = 32'h7FC00001;
      #1;
      checks++;
`ifdef FP_WB_BYPASS_EN
      if (bus.issue_ready !== 1'b1) begin
         errors++; $display("FAIL waw_wb_cycle ready %b want 1", bus.issue_ready);
      end
`else
      if (bus.issue_ready !== 1'b0) begin
         errors++; $display("FAIL waw_wb_cycle ready %b want 0", bus.issue_ready);
      end
`endif
      tick();
      bus.wb_en = 0;
      #1;
      checks++;
      if (bus.issue_ready !== 1'b1 || bus.busy_vec !== 16'h0000) begin
         errors++; $display("FAIL waw_after ready %b busy %h want 1 0000", bus.issue_ready,
                            bus.busy_vec);
      end
   endtask

   task automatic test_load_busy();
      clear_inputs();
      bus.issue_valid = 1; bus.issue_dest = 4'd5; bus.rd_addr_a = 4'd0; bus.rd_addr_b = 4'd1;
      tick();
      clear_inputs();
      bus.load_en = 1; bus.load_addr = 4'd5; bus.load_data = 32'h12345678;
      tick();
      clear_inputs();
      bus.rd_addr_a = 4'd5;
      #1;
      checks++;
      if (bus.load_err !== 1'b1) begin
         errors++; $display("FAIL load_busy_err got %b want 1", bus.load_err);
      end
      checks++;
      if (bus.rd_data_a !== 32'h7FC00001) begin
         errors++; $display("FAIL load_busy_data got %h want 7fc00001", bus.rd_data_a);
      end
      tick();
      checks++;
      if (bus.load_err !== 1'b0) begin
         errors++; $display("FAIL load_busy_pulse got %b want 0", bus.load_err);
      end
      bus.wb_en = 1; bus.wb_dest = 4'd5; bus.wb_data = 32'hFF800000;
      tick();
      bus.wb_en = 0;
      #1;
      checks++;
      if (bus.rd_data_a !== 32'hFF800000 || bus.idle !== 1'b1) begin
         errors++; $display("FAIL load_busy_clear rd %h idle %b want ff800000 1", bus.rd_data_a,
                            bus.idle);
      end
   endtask

`ifdef FP_WB_BYPASS_EN
   task automatic test_bypass();
      clear_inputs();
      bus.wb_en = 1; bus.wb_dest = 4'd7; bus.wb_data = 32'hC0A00000;
      bus.rd_addr_a = 4'd7;
      #1;
      checks++;
      if (bus.rd_data_a !== 32'hC0A00000) begin
         errors++; $display("FAIL bypass_rd got %h want c0a00000", bus.rd_data_a);
      end
      tick();
      clear_inputs();
   endtask
`endif

   task automatic test_random();
      logic [3:0] pick;
      for (int cyc = 0; cyc < 400; cyc++) begin
         bus.rd_addr_a   = 4'($urandom_range(0, 15));
         bus.rd_addr_b   = 4'($urandom_range(0, 15));
         bus.issue_valid = ($urandom_range(0, 1) == 1);
         bus.issue_dest  = 4'($urandom_range(0, 15));
         bus.load_en     = ($urandom_range(0, 4) == 0);
         bus.load_addr   = 4'($urandom_range(0, 15));
         bus.load_data   = $urandom;
         bus.wb_en       = ($urandom_range(0, 2) == 0);
         pick            = 4'($urandom_range(0, 15));
         for (int k = 0; k < 16; k++) begin
            if (m_busy[4'(pick + k)]) begin
               pick = 4'(pick + k);
               break;
            end
         end
         bus.wb_dest = pick;
         bus.wb_data = $urandom;
         #1;
         checks++;
         if (bus.rd_data_a !== exp_rd(bus.rd_addr_a) || bus.rd_data_b !== exp_rd(bus.rd_addr_b))
         begin
            errors++;
            $display("FAIL rand_rd cyc %0d got %h %h want %h %h", cyc, bus.rd_data_a,
                     bus.rd_data_b, exp_rd(bus.rd_addr_a), exp_rd(bus.rd_addr_b));
         end
         checks++;
         if (bus.issue_ready !== exp_ready() ||
             bus.issue_fire !== (bus.issue_valid && exp_ready())) begin
            errors++;
            $display("FAIL rand_issue cyc %0d ready %b fire %b want %b %b", cyc, bus.issue_ready,
                     bus.issue_fire, exp_ready(), bus.issue_valid && exp_ready());
         end
         checks++;
         if (bus.busy_vec !== m_busy || bus.idle !== (m_busy == 16'h0) ||
             bus.load_err !== m_lerr) begin
            errors++;
            $display("FAIL rand_state cyc %0d busy %h idle %b lerr %b want %h %b %b", cyc,
                     bus.busy_vec, bus.idle, bus.load_err, m_busy, m_busy == 16'h0, m_lerr);
         end
         tick();
      end
      clear_inputs();
   endtask

   task automatic test_reset_midflight();
      clear_inputs();
      // drain anything left busy so the target pattern is exact
      for (int i = 0; i < 16; i++) begin
         if (m_busy[i]) begin
            bus.wb_en = 1; bus.wb_dest = 4'(i); bus.wb_data = $urandom;
            tick();
         end
      end
      clear_inputs();
      bus.rd_addr_a = 4'd0; bus.rd_addr_b = 4'd1;
      bus.issue_valid = 1; bus.issue_dest = 4'd5;
      tick();
      bus.issue_dest = 4'd7;
      tick();
      clear_inputs();
      #1;
      checks++;
      if (bus.busy_vec !== 16'h00A0) begin
         errors++; $display("FAIL midflight_pre got %h want 00a0", bus.busy_vec);
      end
      #2;
      nreset = 1'b0;
      model_reset();
      #1;
      checks++;
      if (bus.busy_vec !== 16'h0000 || bus.idle !== 1'b1) begin
         errors++; $display("FAIL midflight_busy got %h idle %b want 0000 1", bus.busy_vec,
                            bus.idle);
      end
      for (int i = 0; i < 16; i++) begin
         bus.rd_addr_a = 4'(i);
         #1;
         checks++;
         if (bus.rd_data_a !== 32'h0) begin
            errors++; $display("FAIL midflight_reg r%0d got %h want 0", i, bus.rd_data_a);
         end
      end
      @(negedge tb_clk);
      nreset = 1'b1;
      // writeback after reset still lands even though nothing is busy
      bus.wb_en = 1; bus.wb_dest = 4'd2; bus.wb_data = 32'h7F800000;
      tick();
      clear_inputs();
      bus.rd_addr_a = 4'd2;
      #1;
      checks++;
      if (bus.rd_data_a !== 32'h7F800000 || bus.busy_vec !== 16'h0000) begin
         errors++; $display("FAIL post_reset_wb rd %h busy %h want 7f800000 0000", bus.rd_data_a,
                            bus.busy_vec);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_load();
      test_raw();
      test_waw();
      test_load_busy();
`ifdef FP_WB_BYPASS_EN
      test_bypass();
`endif
      test_random();
      test_reset_midflight();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
